encoder_4to2_arb: RTL and testbench

//  Registered 4-to-2 encoder/arbiter: the inverse of the 2-to-4 decoder. It captures
//  one-hot or multi-hot request lines and emits one binary index at a time on a

---
 rtl/encoder_4to2_arb_pkg.sv | 14 +
 rtl/encoder_4to2_arb_prio_pick.sv | 39 +++
 rtl/encoder_4to2_arb.sv | 88 ++++++++
 tb/tb_encoder_4to2_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_4to2_arb_pkg.sv
// Shared types and helpers for the registered 4-to-2 encoder/arbiter.
package encoder_4to2_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Index width for n request lines; a single line still needs one bit.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/encoder_4to2_arb_prio_pick.sv
// Combinational picker: highest set index, or first set index upward from ptr with wrap.
module prio_pick
  import encoder_4to2_arb_pkg::*;
#(
  parameter int N = 4,
  parameter bit RR = 1'b0,
  localparam int CW = cw_of(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] idx,
  output logic          any
);

  assign any = |vec;

  generate
    if (RR) begin : g_rr
      // Walk downward in search distance so the nearest set bit from ptr is written last.
      always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
          if (vec[(int'(ptr) + k) % N]) idx = CW'((int'(ptr) + k) % N);
        end
      end
    end else begin : g_fixed
      logic unused_ptr;
      assign unused_ptr = ^ptr;

      always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
          if (vec[i]) idx = CW'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/encoder_4to2_arb.sv
// Registered encoder/arbiter: sticky pending requests issued one index at a time over valid/ack.
module encoder_4to2_arb
  import encoder_4to2_arb_pkg::*;
#(
  parameter int N = 4,
  parameter bit RR = 1'b0,
  localparam int CW = cw_of(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [CW-1:0] code,
  output logic          valid,
  output logic [N-1:0]  pending
);

  state_t        state;
  logic [CW-1:0] rr_ptr;
  logic          xfer;
  logic [N-1:0]  clr;
  logic [N-1:0]  kept;
  logic [N-1:0]  nxt;
  logic [CW-1:0] ptr_next;
  logic [CW-1:0] idle_idx;
  logic          idle_any;
  logic [CW-1:0] b2b_idx;
  logic          b2b_any;

  assign xfer = valid & ack;
  assign clr  = xfer ? (N'(1) << code) : '0;
  assign kept = pending & ~clr;
  // Requests are OR-ed after the clear, so a re-request on the granted line survives.
  assign nxt  = en ? (kept | req) : kept;
  assign ptr_next = (code == CW'(N - 1)) ? '0 : code + CW'(1);

  prio_pick #(.N(N), .RR(RR)) u_pick_idle (
    .vec (pending),
    .ptr (rr_ptr),
    .idx (idle_idx),
    .any (idle_any)
  );

  prio_pick #(.N(N), .RR(RR)) u_pick_b2b (
    .vec (nxt),
    .ptr (ptr_next),
    .idx (b2b_idx),
    .any (b2b_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      code    <= '0;
      valid   <= 1'b0;
      state   <= ST_IDLE;
      rr_ptr  <= '0;
    end else begin
      pending <= nxt;
      case (state)
        ST_IDLE: begin
          if (en && idle_any) begin
            code  <= idle_idx;
            valid <= 1'b1;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (ack) begin
            rr_ptr <= ptr_next;
            if (en && b2b_any) begin
              code <= b2b_idx;
            end else begin
              valid <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          valid <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_4to2_arb.sv
// Scoreboard bench driving a fixed-priority and a round-robin arbiter with shared stimulus.
module tb_encoder_4to2_arb;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       ack;
  logic [1:0] code_fx;
  logic       valid_fx;
  logic [3:0] pending_fx;
  logic [1:0] code_rr;
  logic       valid_rr;
  logic [3:0] pending_rr;

  int vectors;
  int miscompares;

  typedef struct {
    logic [1:0] code_fx;
    logic       valid_fx;
    logic [3:0] pending_fx;
    logic [1:0] code_rr;
    logic       valid_rr;
    logic [3:0] pending_rr;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_rec;

  // Reference model state, index 0 = fixed priority, 1 = round robin.
  int         m_valid[2];
  int         m_code[2];
  int         m_ptr[2];
  logic [3:0] m_pend[2];

  encoder_4to2_arb #(.N(4), .RR(1'b0)) dut_fx (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .ack     (ack),
    .code    (code_fx),
    .valid   (valid_fx),
    .pending (pending_fx)
  );

  encoder_4to2_arb #(.N(4), .RR(1'b1)) dut_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .ack     (ack),
    .code    (code_rr),
    .valid   (valid_rr),
    .pending (pending_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr, input int rr);
    if (rr == 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (v[i]) return i;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      end
    end
    return 0;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0;
      m_code[d]  = 0;
      m_ptr[d]   = 0;
      m_pend[d]  = 4'b0000;
    end
  endtask

  task automatic modelStep(input logic en_i, input logic [3:0] req_i, input logic ack_i);
    for (int d = 0; d < 2; d++) begin
      logic [3:0] after;
      after = m_pend[d];
      if (m_valid[d] != 0 && ack_i) after[m_code[d]] = 1'b0;
      if (en_i) after = after | req_i;
      if (m_valid[d] == 0) begin
        if (en_i && m_pend[d] != 4'b0000) begin
          m_valid[d] = 1;
          m_code[d]  = pick(m_pend[d], m_ptr[d], d);
        end
      end else if (ack_i) begin
        m_ptr[d] = (m_code[d] + 1) % 4;
        if (en_i && after != 4'b0000) m_code[d] = pick(after, m_ptr[d], d);
        else m_valid[d] = 0;
      end
      m_pend[d] = after;
    end
  endtask

  function automatic rec_t modelSnapshot();
    rec_t r;
    r.code_fx    = 2'(m_code[0]);
    r.valid_fx   = (m_valid[0] != 0);
    r.pending_fx = m_pend[0];
    r.code_rr    = 2'(m_code[1]);
    r.valid_rr   = (m_valid[1] != 0);
    r.pending_rr = m_pend[1];
    return r;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic applyStimulus(input logic en_i, input logic [3:0] req_i, input logic ack_i);
    exp_q.push_back(modelSnapshot());
    en  = en_i;
    req = req_i;
    ack = ack_i;
    modelStep(en_i, req_i, ack_i);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'b0000, 1'b1);
  endtask

  // Monitor compares mid-cycle, when registered outputs are settled.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_rec = exp_q.pop_front();
      checkOutput("sb_valid_fx",   8'(valid_fx),   8'(mon_rec.valid_fx));
      checkOutput("sb_code_fx",    8'(code_fx),    8'(mon_rec.code_fx));
      checkOutput("sb_pending_fx", 8'(pending_fx), 8'(mon_rec.pending_fx));
      checkOutput("sb_valid_rr",   8'(valid_rr),   8'(mon_rec.valid_rr));
      checkOutput("sb_code_rr",    8'(code_rr),    8'(mon_rec.code_rr));
      checkOutput("sb_pending_rr", 8'(pending_rr), 8'(mon_rec.pending_rr));
    end
  end

  initial begin
    logic [3:0] rq;
    logic [1:0] rr_seq [6];
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    ack   = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fixed priority drains a multi-hot burst highest first.
    applyStimulus(1'b1, 4'b1011, 1'b1);
    checkOutput("t2_pending", 8'(pending_fx), 8'd11);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("t2_code_a", 8'(code_fx), 8'd3);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("t2_code_b", 8'(code_fx), 8'd1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("t2_code_c", 8'(code_fx), 8'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("t2_valid_end", 8'(valid_fx), 8'd0);
    checkOutput("t2_pending_end", 8'(pending_fx), 8'd0);
    drain();

    // Code holds while unacknowledged even when a higher request arrives.
    applyStimulus(1'b1, 4'b0010, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, (i == 1) ? 4'b1000 : 4'b0000, 1'b0);
      checkOutput("t3_hold_code", 8'(code_fx), 8'd1);
      checkOutput("t3_hold_valid", 8'(valid_fx), 8'd1);
    end
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("t3_next_code", 8'(code_fx), 8'd3);
    drain();

    // Re-request on the line being acknowledged is re-granted.
    applyStimulus(1'b1, 4'b0100, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t5_code_first", 8'(code_fx), 8'd2);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("t5_pending_bit", 8'(pending_fx[2]), 8'd1);
    checkOutput("t5_code_again", 8'(code_fx), 8'd2);
    checkOutput("t5_valid_again", 8'(valid_fx), 8'd1);
    drain();

    // Disabled capture, then enable dropped during a grant.
    applyStimulus(1'b0, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("t6_pending_off", 8'(pending_fx), 8'd0);
    checkOutput("t6_valid_off", 8'(valid_fx), 8'd0);
    applyStimulus(1'b1, 4'b1100, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("t6_grant_held", 8'(valid_fx), 8'd1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("t6_idle_after_ack", 8'(valid_fx), 8'd0);
    checkOutput("t6_pending_kept", 8'(pending_fx), 8'd4);
    drain();

    // Asynchronous reset in the middle of a grant of index 3.
    applyStimulus(1'b1, 4'b1000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t1_pre_code", 8'(code_fx), 8'd3);
    checkOutput("t1_pre_valid", 8'(valid_fx), 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_valid", 8'(valid_fx), 8'd0);
    checkOutput("t1_code", 8'(code_fx), 8'd0);
    checkOutput("t1_pending", 8'(pending_fx), 8'd0);
    checkOutput("t1_valid_rr", 8'(valid_rr), 8'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round robin rotates through all lines and wraps 3 -> 0.
    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2;
    rr_seq[3] = 2'd3; rr_seq[4] = 2'd0; rr_seq[5] = 2'd1;
    applyStimulus(1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'b1111, 1'b1);
      checkOutput("t4_rr_code", 8'(code_rr), 8'(rr_seq[i]));
      checkOutput("t4_rr_valid", 8'(valid_rr), 8'd1);
    end
    drain();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rq = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      applyStimulus(($urandom_range(0, 9) != 0), rq, 1'($urandom_range(0, 1)));
    end
    drain();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sb_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
